// File: rtl/alu_serial_add_pkg.sv
// ============================================================================
// Module      : alu_serial_add_pkg
// Description : Shared constants and types for the bit-serial adder: default
//               operand width, bit-counter width and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_serial_add_pkg;

   localparam int ALU_WIDTH     = 5;
   localparam int ALU_CNT_WIDTH = $clog2(ALU_WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage : alu_serial_add_pkg

`default_nettype wire

// File: rtl/alu_serial_add_full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : Single-bit combinational full adder, evaluated once per clock
//               by the serial adder datapath.
// Ports       : a, b, cin  - addend bits and carry in
//               sum, cout  - sum bit and carry out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

`default_nettype wire

// File: rtl/alu_serial_add.sv
// ============================================================================
// Module      : alu_serial_add
// Description : Bit-serial adder, LSB first, one full-adder step per clock.
//               {carry_out, result} = operand_a + operand_b + carry_in.
// Ports       : clk, rst (async, active-high)
//               start, operand_a, operand_b, carry_in - request and operands
//               busy     - high while an addition is in progress
//               done     - one-cycle pulse when the outputs update
//               result, carry_out, overflow - last completed operation
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_serial_add
   import alu_serial_add_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   // Counter width is clog2(WIDTH); the package value covers the default width.
   localparam int CNT_W = (WIDTH == ALU_WIDTH) ? ALU_CNT_WIDTH : $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, b_sh, acc_sh;
   logic             c;
   logic [CNT_W-1:0] cnt;

   logic             capture;
   logic             step;
   logic             finish;
   logic             sum_bit;
   logic             cout_bit;

   full_adder u_full_adder (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (c),
      .sum  (sum_bit),
      .cout (cout_bit)
   );

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath control
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            // start is only looked at here, so requests while busy are dropped
            if (start) begin
               capture    = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == LAST_BIT) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Shift registers, carry and counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         acc_sh <= '0;
         c      <= 1'b0;
         cnt    <= '0;
      end else if (capture) begin
         a_sh <= operand_a;
         b_sh <= operand_b;
         c    <= carry_in;
         cnt  <= '0;
      end else if (step) begin
         acc_sh <= {sum_bit, acc_sh[WIDTH-1:1]};
         a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
         c      <= cout_bit;
         cnt    <= cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Handshake and result registers; results move only on the final bit
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         busy <= (state_next == RUN);
         done <= finish;
         if (finish) begin
            result    <= {sum_bit, acc_sh[WIDTH-1:1]};
            carry_out <= cout_bit;
            // c still holds the carry into the MSB at this point
            overflow  <= c ^ cout_bit;
         end
      end
   end

endmodule : alu_serial_add

`default_nettype wire

// File: tb/tb_alu_serial_add.sv
// ============================================================================
// Module      : tb_alu_serial_add
// Description : Directed self-checking bench for the bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_serial_add;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] operand_a = '0;
   logic [W-1:0] operand_b = '0;
   logic         carry_in = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   int checks   = 0;
   int failures = 0;

   alu_serial_add #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .carry_in  (carry_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one add from IDLE and check the handshake and outputs.
   task automatic run_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] er, input logic eco,
                          input logic eov);
      int busy_cycles;
      int early_done;
      operand_a = a;
      operand_b = b;
      carry_in  = cin;
      start     = 1'b1;
      step();
      start       = 1'b0;
      operand_a   = '0;
      operand_b   = '0;
      carry_in    = 1'b0;
      busy_cycles = busy ? 1 : 0;
      early_done  = done ? 1 : 0;
      for (int i = 1; i < W; i++) begin
         step();
         if (busy) busy_cycles++;
         if (done) early_done++;
      end
      step();
      chk({tag, "_early_done"}, early_done, 0);
      chk({tag, "_busy_cycles"}, busy_cycles, W);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_result"}, result, er);
      chk({tag, "_carry"}, carry_out, eco);
      chk({tag, "_ovf"}, overflow, eov);
      step();
      chk({tag, "_done_drop"}, done, 0);
   endtask

   initial begin
      int n_done;

      // Reset
      rst = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_carry", carry_out, 0);
      chk("rst_ovf", overflow, 0);
      step();
      step();
      rst = 1'b0;
      step();

      // 7+9=16: carry into MSB=1, out=0 -> signed overflow
      run_add("add7_9", 5'd7, 5'd9, 1'b0, 5'd16, 1'b0, 1'b1);
      run_add("add31_1", 5'd31, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0);
      run_add("add15_1", 5'd15, 5'd1, 1'b0, 5'd16, 1'b0, 1'b1);
      run_add("add16_16", 5'd16, 5'd16, 1'b0, 5'd0, 1'b1, 1'b1);
      run_add("add31_31c", 5'd31, 5'd31, 1'b1, 5'd31, 1'b1, 1'b0);

      // Start while busy is ignored; start during the done cycle is accepted
      operand_a = 5'd3;
      operand_b = 5'd4;
      carry_in  = 1'b0;
      start     = 1'b1;
      step();                       // edge 0: accepted
      start = 1'b0;
      step();                       // edge 1
      operand_a = 5'd10;
      operand_b = 5'd10;
      start     = 1'b1;
      step();                       // edge 2: busy, must be ignored
      start  = 1'b0;
      n_done = 0;
      for (int i = 3; i < W; i++) begin
         step();
         if (done) n_done++;
      end
      step();                       // edge W
      chk("b2b_first_done", done, 1);
      chk("b2b_first_result", result, 7);
      chk("b2b_first_ovf", overflow, 0);
      chk("b2b_early_done", n_done, 0);
      operand_a = 5'd10;
      operand_b = 5'd10;
      start     = 1'b1;             // sampled during the done cycle
      step();
      start = 1'b0;
      chk("b2b_accept_busy", busy, 1);
      chk("b2b_single_done", done, 0);
      n_done = 0;
      for (int i = 1; i < W; i++) begin
         step();
         if (done) n_done++;
         chk("b2b_hold_result", result, 7);
      end
      step();
      chk("b2b_mid_done", n_done, 0);
      chk("b2b_second_done", done, 1);
      chk("b2b_second_result", result, 20);
      chk("b2b_second_carry", carry_out, 0);
      chk("b2b_second_ovf", overflow, 1);
      step();

      // Reset in the middle of an add
      operand_a = 5'd5;
      operand_b = 5'd6;
      start     = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_result", result, 0);
      chk("abort_ovf", overflow, 0);
      step();
      rst    = 1'b0;
      n_done = 0;
      for (int i = 0; i < W + 2; i++) begin
         step();
         if (done || busy) n_done++;
      end
      chk("abort_no_done", n_done, 0);
      run_add("add1_2", 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule : tb_alu_serial_add

`default_nettype wire
